// File: rtl/ising_axi_cell_bridge.sv
// AXI4-Lite slave bridging host accesses to the Ising array spin-load bus:
// one-hot cell write strobes, broadcast write data, read-back mux and the CTRL register.
module ising_axi_cell_bridge #(
  parameter int NUM_CELLS = 8,
  parameter int ADDR_W    = 12
) (
  input  logic                    clk,
  input  logic                    axi_rstn,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [31:0]             s_wdata,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_W-1:0]       s_araddr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    cell_wready,
  output logic [NUM_CELLS-1:0]    cell_addr_match,
  output logic [31:0]             cell_wdata,
  input  logic [32*NUM_CELLS-1:0] cell_rdata,
  output logic                    ising_rstn,
  output logic                    start,
  output logic [1:0]              wr_state_dbg,
  output logic                    rd_state_dbg
);

  localparam int IDX_W = ADDR_W - 2;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // valid/data are held by the sender until then, ready is a registered output here.

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  wr_state_t            wr_state;
  rd_state_t            rd_state;
  logic                 aw_held;
  logic                 w_held;
  logic [IDX_W-1:0]     aw_idx_q;
  logic                 wr_ctrl_q;
  logic                 wr_mapped_q;
  logic [1:0]           ctrl_q;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 ar_hs;
  logic [IDX_W-1:0]     wr_idx;
  logic [NUM_CELLS-1:0] wr_match;
  logic                 wr_is_ctrl;
  logic [IDX_W-1:0]     rd_idx;
  logic [31:0]          rd_word;
  logic [1:0]           rd_resp;
  logic                 unused_addr_bits;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign ising_rstn   = ctrl_q[0];
  assign start        = ctrl_q[1];
  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  // The address decoded for the strobe is the one arriving now or the one already held.
  assign wr_idx = aw_hs ? s_awaddr[ADDR_W-1:2] : aw_idx_q;

  always_comb begin
    wr_match   = '0;
    wr_is_ctrl = (wr_idx == '0);
    for (int i = 0; i < NUM_CELLS; i++) begin
      wr_match[i] = (wr_idx == IDX_W'(i + 1));
    end
  end

  assign rd_idx = s_araddr[ADDR_W-1:2];

  always_comb begin
    rd_word = 32'hDEAD_BEEF;
    rd_resp = 2'b10;
    if (rd_idx == '0) begin
      rd_word = {30'd0, ctrl_q[1], ctrl_q[0]};
      rd_resp = 2'b00;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (rd_idx == IDX_W'(i + 1)) begin
        rd_word = cell_rdata[32*i +: 32];
        rd_resp = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_state        <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_idx_q        <= '0;
      wr_ctrl_q       <= 1'b0;
      wr_mapped_q     <= 1'b0;
      ctrl_q          <= 2'b00;
      s_awready       <= 1'b0;
      s_wready        <= 1'b0;
      s_bvalid        <= 1'b0;
      s_bresp         <= 2'b00;
      cell_wready     <= 1'b0;
      cell_addr_match <= '0;
      cell_wdata      <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= s_awaddr[ADDR_W-1:2];
          end
          if (w_hs) begin
            w_held     <= 1'b1;
            cell_wdata <= s_wdata;
          end
          s_awready <= ~(aw_held | aw_hs);
          s_wready  <= ~(w_held | w_hs);
          if ((aw_held | aw_hs) && (w_held | w_hs)) begin
            wr_state        <= W_EXEC;
            cell_wready     <= |wr_match;
            cell_addr_match <= wr_match;
            wr_ctrl_q       <= wr_is_ctrl;
            wr_mapped_q     <= wr_is_ctrl | (|wr_match);
          end
        end
        W_EXEC: begin
          cell_wready     <= 1'b0;
          cell_addr_match <= '0;
          if (wr_ctrl_q) begin
            ctrl_q <= cell_wdata[1:0];
          end
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
          s_bvalid <= 1'b1;
          s_bresp  <= wr_mapped_q ? 2'b00 : 2'b10;
          wr_state <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: begin
          wr_state        <= W_IDLE;
          cell_wready     <= 1'b0;
          cell_addr_match <= '0;
          s_bvalid        <= 1'b0;
        end
      endcase
    end
  end

  // Read data is sampled on the AR edge; a concurrent write is not forwarded.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_state  <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
    end else begin
      case (rd_state)
        R_IDLE: begin
          s_arready <= ~ar_hs;
          if (ar_hs) begin
            s_rdata  <= rd_word;
            s_rresp  <= rd_resp;
            s_rvalid <= 1'b1;
            rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
          s_rvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ising_axi_cell_bridge.sv
// Scoreboarded bench for ising_axi_cell_bridge: cell strobes, B responses and
// read data are predicted when stimulus is driven and compared when the DUT responds.
module tb_ising_axi_cell_bridge;

  localparam int NUM_CELLS = 8;
  localparam int ADDR_W    = 12;

  logic                    clk = 1'b0;
  logic                    axi_rstn;
  logic                    s_awvalid, s_awready;
  logic [ADDR_W-1:0]       s_awaddr;
  logic                    s_wvalid, s_wready;
  logic [31:0]             s_wdata;
  logic                    s_bvalid, s_bready;
  logic [1:0]              s_bresp;
  logic                    s_arvalid, s_arready;
  logic [ADDR_W-1:0]       s_araddr;
  logic                    s_rvalid, s_rready;
  logic [31:0]             s_rdata;
  logic [1:0]              s_rresp;
  logic                    cell_wready;
  logic [NUM_CELLS-1:0]    cell_addr_match;
  logic [31:0]             cell_wdata;
  logic [32*NUM_CELLS-1:0] cell_rdata;
  logic                    ising_rstn, start;
  logic [1:0]              wr_state_dbg;
  logic                    rd_state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [39:0] strobe_q[$];   // {match, wdata}
  logic [1:0]  b_exp_q[$];
  logic [33:0] exp_q[$];      // {rresp, rdata}
  logic [31:0] cell_words[NUM_CELLS];
  logic [1:0]  ctrl_model;

  ising_axi_cell_bridge #(.NUM_CELLS(NUM_CELLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .axi_rstn(axi_rstn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cell_wready(cell_wready), .cell_addr_match(cell_addr_match),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata),
    .ising_rstn(ising_rstn), .start(start),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobe monitor: every cell_wready cycle must match the next predicted strobe.
  always @(negedge clk) begin
    if (cell_wready) begin
      if (strobe_q.size() == 0) begin
        check("unexpected_strobe", {24'd0, cell_addr_match}, 32'd0);
      end else begin
        logic [39:0] e;
        e = strobe_q.pop_front();
        check("strobe_match", {24'd0, cell_addr_match}, {24'd0, e[39:32]});
        check("strobe_wdata", cell_wdata, e[31:0]);
      end
    end else if (cell_addr_match != '0) begin
      check("match_idle", {24'd0, cell_addr_match}, 32'd0);
    end
  end

  function automatic logic [33:0] model_read(input logic [ADDR_W-1:0] addr);
    int idx;
    idx = int'(addr[ADDR_W-1:2]);
    if (idx == 0) return {2'b00, 30'd0, ctrl_model};
    if (idx <= NUM_CELLS) return {2'b00, cell_words[idx-1]};
    return {2'b10, 32'hDEAD_BEEF};
  endfunction

  task automatic load_cells();
    for (int i = 0; i < NUM_CELLS; i++) cell_rdata[32*i +: 32] = cell_words[i];
  endtask

  // Driver tasks
  task automatic write_req(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input int aw_delay, input int w_delay, input bit is_cell);
    bit aw_done, w_done, aw_now, w_now;
    aw_done = 0;
    w_done  = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (!aw_done && c == aw_delay) begin s_awvalid = 1'b1; s_awaddr = addr; end
      if (!w_done && c == w_delay) begin s_wvalid = 1'b1; s_wdata = data; end
      @(negedge clk);
      aw_now = s_awvalid & s_awready;
      w_now  = s_wvalid & s_wready;
      @(posedge clk); #1;
      if (aw_now) begin aw_done = 1; s_awvalid = 1'b0; end
      if (w_now) begin w_done = 1; s_wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      check("wr_hs_timeout", 32'd0, 32'd1);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      return;
    end
    @(negedge clk);
    check("strobe_lat", {31'd0, cell_wready}, {31'd0, is_cell});
    @(negedge clk);
    check("b_lat", {31'd0, s_bvalid}, 32'd1);
  endtask

  task automatic write_resp(input int bdelay);
    logic [1:0] e;
    int t;
    t = 0;
    while (!s_bvalid && t < 20) begin @(negedge clk); t++; end
    if (!s_bvalid) begin check("b_timeout", 32'd0, 32'd1); return; end
    for (int k = 0; k < bdelay; k++) begin
      check("b_hold", {31'd0, s_bvalid}, 32'd1);
      @(negedge clk);
    end
    e = b_exp_q.pop_front();
    check("bresp", {30'd0, s_bresp}, {30'd0, e});
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input int aw_delay, input int w_delay, input int bdelay);
    int idx;
    bit is_cell;
    idx = int'(addr[ADDR_W-1:2]);
    is_cell = (idx >= 1 && idx <= NUM_CELLS);
    if (is_cell) strobe_q.push_back({8'(1 << (idx - 1)), data});
    b_exp_q.push_back((idx <= NUM_CELLS) ? 2'b00 : 2'b10);
    write_req(addr, data, aw_delay, w_delay, is_cell);
    write_resp(bdelay);
    if (idx == 0) ctrl_model = data[1:0];
  endtask

  task automatic read_req(input logic [ADDR_W-1:0] addr);
    bit hs;
    hs = 0;
    exp_q.push_back(model_read(addr));
    @(posedge clk); #1;
    s_arvalid = 1'b1;
    s_araddr  = addr;
    for (int c = 0; c < 40 && !hs; c++) begin
      @(negedge clk);
      hs = s_arvalid & s_arready;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    if (!hs) begin check("ar_timeout", 32'd0, 32'd1); return; end
    @(negedge clk);
    check("r_lat", {31'd0, s_rvalid}, 32'd1);
  endtask

  task automatic read_resp(input int rdelay);
    logic [33:0] e;
    int t;
    t = 0;
    while (!s_rvalid && t < 20) begin @(negedge clk); t++; end
    e = exp_q.pop_front();
    if (!s_rvalid) begin check("r_timeout", 32'd0, 32'd1); return; end
    for (int k = 0; k < rdelay; k++) begin
      check("r_hold", s_rdata, e[31:0]);
      @(negedge clk);
    end
    check("rdata", s_rdata, e[31:0]);
    check("rresp", {30'd0, s_rresp}, {30'd0, e[33:32]});
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int rdelay);
    read_req(addr);
    read_resp(rdelay);
  endtask

  initial begin
    axi_rstn  = 1'b0;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_bready = 0;
    s_arvalid = 0; s_araddr = '0; s_rready = 0;
    ctrl_model = 2'b00;
    for (int i = 0; i < NUM_CELLS; i++) cell_words[i] = $urandom;
    cell_words[3] = 32'hA5A5_0001;
    load_cells();

    repeat (3) @(negedge clk);
    check("rst_ising_rstn", {31'd0, ising_rstn}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_awready", {31'd0, s_awready}, 32'd0);
    check("rst_rvalid_bvalid", {30'd0, s_rvalid, s_bvalid}, 32'd0);
    check("rst_cell_wready", {31'd0, cell_wready}, 32'd0);
    axi_rstn = 1'b1;
    @(negedge clk);
    check("awready_after_rst", {31'd0, s_awready}, 32'd1);
    check("arready_after_rst", {31'd0, s_arready}, 32'd1);

    axi_read(12'h000, 0);
    check("ising_rstn_idle", {31'd0, ising_rstn}, 32'd0);

    // AW and W together, then W leading by two, then AW leading with B back-pressure
    axi_write(12'h00C, 32'h1, 0, 0, 0);
    axi_write(12'h004, 32'h1234_5678, 2, 0, 0);
    axi_write(12'h004, 32'h0BAD_F00D, 0, 2, 5);

    axi_write(12'h000, 32'h3, 0, 0, 0);
    check("ctrl_ising_rstn", {31'd0, ising_rstn}, 32'd1);
    check("ctrl_start", {31'd0, start}, 32'd1);
    axi_read(12'h010, 3);
    axi_read(12'h000, 0);

    axi_write(12'h040, 32'hFFFF_FFFF, 0, 0, 0);
    axi_read(12'h040, 1);

    for (int n = 0; n < 6; n++) begin
      int c;
      c = $urandom_range(0, NUM_CELLS - 1);
      axi_write(ADDR_W'((c + 1) * 4 + $urandom_range(0, 3)), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      c = $urandom_range(0, NUM_CELLS - 1);
      axi_read(ADDR_W'((c + 1) * 4), $urandom_range(0, 2));
    end

    // Reset during W_RESP: response and CTRL are dropped immediately.
    strobe_q.push_back({8'b0000_0010, 32'hCAFE_0002});
    write_req(12'h008, 32'hCAFE_0002, 0, 0, 1'b1);
    axi_rstn = 1'b0;
    #1;
    check("abort_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("abort_ctrl", {30'd0, start, ising_rstn}, 32'd0);
    ctrl_model = 2'b00;
    repeat (2) @(negedge clk);
    axi_rstn = 1'b1;

    // Reset during R_RESP
    read_req(12'h000);
    axi_rstn = 1'b0;
    #1;
    check("abort_rvalid", {31'd0, s_rvalid}, 32'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    axi_rstn = 1'b1;

    axi_write(12'h018, 32'h5555_AAAA, 0, 1, 0);
    axi_read(12'h000, 0);
    axi_read(12'h014, 0);

    repeat (3) @(negedge clk);
    check("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
    check("exp_q_empty", 32'(exp_q.size() + b_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
